hilo_muldiv_sequencer: RTL

Multi-cycle multiply/divide controller that owns the HI/LO register pair for the 5-stage MIPS pipeline. It sits beside the EX-stage ALU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, runs a 32-iteration shift-add or restoring-divide sequence, and drives a stall to the hazard logic whenever a HI/LO consumer or a new mul/div reaches EX while a sequence is in flight.

---
 rtl/hilo_muldiv_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv_sequencer.sv
// HI/LO owner beside the EX-stage ALU: 32-step shift-add multiply and
// restoring divide, MTHI/MTLO writes, and the hazard stall for HI/LO users.
module hilo_muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             HiLoRead,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q_q, neg_q_d;
  logic                 neg_r_q, neg_r_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  logic                 is_mul, is_div, is_mthi, is_mtlo;
  logic                 sgn, a_neg, b_neg, b_zero, last;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum, rem_sh, div_trial;
  logic                 div_ok;
  logic [2*WIDTH-1:0]   mul_next, div_next, prod;
  logic [WIDTH-1:0]     quo, rem;

  always_comb begin
    is_mul  = (Op == OP_MULT) | (Op == OP_MULTU);
    is_div  = (Op == OP_DIV) | (Op == OP_DIVU);
    is_mthi = (Op == OP_MTHI);
    is_mtlo = (Op == OP_MTLO);
    sgn     = (Op == OP_MULT) | (Op == OP_DIV);
    a_neg   = sgn & OperandA[WIDTH-1];
    b_neg   = sgn & OperandB[WIDTH-1];
    a_mag   = a_neg ? -OperandA : OperandA;
    b_mag   = b_neg ? -OperandB : OperandB;
    b_zero  = (OperandB == '0);
    last    = (cnt_q == CNT_W'(WIDTH-1));
  end

  // Multiplier sits in the low half and shifts out as the product shifts in.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
            + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  end

  // Remainder in the high half, dividend/quotient in the low half.
  always_comb begin
    rem_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial = rem_sh - {1'b0, opb_q};
    div_ok    = ~div_trial[WIDTH];
    div_next  = {div_ok ? div_trial[WIDTH-1:0] : rem_sh[WIDTH-1:0],
                 acc_q[WIDTH-2:0], div_ok};
  end

  always_comb begin
    prod = neg_q_q ? -acc_q : acc_q;
    quo  = neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem  = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH]
                   : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          unique case (1'b1)
            is_mthi: hi_d = OperandA;
            is_mtlo: lo_d = OperandA;
            is_mul: begin
              acc_d    = {{WIDTH{1'b0}}, b_mag};
              opb_d    = a_mag;
              neg_q_d  = a_neg ^ b_neg;
              neg_r_d  = 1'b0;
              is_div_d = 1'b0;
              cnt_d    = '0;
              busy_d   = 1'b1;
              state_d  = MUL;
            end
            is_div && b_zero: begin
              done_d = 1'b1;
              dbz_d  = 1'b1;
            end
            is_div && !b_zero: begin
              acc_d    = {{WIDTH{1'b0}}, a_mag};
              opb_d    = b_mag;
              neg_q_d  = a_neg ^ b_neg;
              neg_r_d  = a_neg;
              is_div_d = 1'b1;
              cnt_d    = '0;
              busy_d   = 1'b1;
              state_d  = DIV;
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 1'b1;
        if (last) state_d = FIX;
      end
      DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + 1'b1;
        if (last) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          lo_d = quo;
          hi_d = rem;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        cnt_d   = '0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign Busy      = busy_q;
  assign Stall     = busy_q & (Start | HiLoRead);
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;

endmodule
